// File: rtl/negative_triggered_3bit_down_counter.sv
// Free-running binary down counter clocked on the falling edge of clk.
// Synchronous active-low reset loads RST_VAL; otherwise q decrements and wraps modulo 2^WIDTH.
module negative_triggered_3bit_down_counter #(
  parameter int unsigned          WIDTH   = 3,
  parameter logic [WIDTH-1:0]     RST_VAL = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] q
);

  localparam logic [WIDTH-1:0] One = WIDTH'(1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Modular subtraction gives the 0 -> all-ones wrap for free.
  always_comb begin
    count_d = count_q - One;
  end

  always_ff @(negedge clk) begin
    if (!rst) begin
      count_q <= RST_VAL;
    end else begin
      count_q <= count_d;
    end
  end

  assign q = count_q;

endmodule

// File: tb/tb_negative_triggered_3bit_down_counter.sv
// Directed bench for the falling-edge down counter; expected values are queued when
// stimulus is driven and compared when the DUT output is sampled.
module tb_negative_triggered_3bit_down_counter;

  logic       clk;
  logic       rst;
  logic [2:0] q;

  int unsigned passed;
  int unsigned total;
  logic [2:0]  model;
  logic [2:0]  exp_q[$];

  negative_triggered_3bit_down_counter #(
    .WIDTH  (3),
    .RST_VAL(3'b111)
  ) dut (
    .clk(clk),
    .rst(rst),
    .q  (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag);
    logic [2:0] e;
    total++;
    if (exp_q.size() == 0) begin
      $error("FAIL %s scoreboard empty, q=%0d", tag, q);
    end else begin
      e = exp_q.pop_front();
      assert (q === e) passed++;
      else $error("FAIL %s q=%0d expected %0d", tag, q, e);
    end
  endtask

  // Drive rst mid-cycle, queue the model's next value, then check after the falling edge.
  task automatic step(input logic r, input string tag);
    rst   = r;
    model = r ? model - 3'd1 : 3'd7;
    exp_q.push_back(model);
    @(negedge clk);
    #1;
    check(tag);
  endtask

  // Same as step with rst high, but rst dips low for 3 ns between the edges.
  task automatic glitch_step(input string tag);
    rst   = 1'b1;
    model = model - 3'd1;
    exp_q.push_back(model);
    #2 rst = 1'b0;
    #3 rst = 1'b1;
    @(negedge clk);
    #1;
    check(tag);
  endtask

  // Output must not move on the rising edge.
  task automatic rise_check(input string tag);
    @(posedge clk);
    #1;
    exp_q.push_back(model);
    check(tag);
  endtask

  initial begin
    passed = 0;
    total  = 0;
    model  = 3'd7;
    rst    = 1'b0;

    for (int i = 0; i < 3; i++) step(1'b0, "reset_hold");

    for (int i = 0; i < 7; i++) step(1'b1, "count");

    for (int i = 0; i < 20; i++) begin
      step(1'b1, "wrap_count");
      rise_check("rise_hold");
    end

    for (int i = 0; i < 8 && model != 3'd4; i++) step(1'b1, "seek_four");
    exp_q.push_back(3'd4);
    check("at_four");

    step(1'b0, "mid_reset");
    step(1'b1, "mid_release");

    for (int i = 0; i < 3; i++) glitch_step("glitch_ignored");
    step(1'b1, "after_glitch");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout q=%0d expected bench completion", q);
    $fatal(1, "timeout");
  end

endmodule
